// File: rtl/display_pkg.sv
// Shared definitions for the display-side blocks (peak-hold meter, bar
// encoder and led_driver variants).
//   state_t            : ballistics FSM state encoding
//   LED_CODES_PER_STEP : input codes represented by one LED of the bar
//   *_DEF              : default hold/decay lengths in samples
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } state_t;

  localparam int LED_CODES_PER_STEP = 8;

  // 0.5 s of hold at 44 kHz, then one LSB of decay every 512 samples.
  localparam int HOLD_SAMPLES_DEF  = 22000;
  localparam int DECAY_SAMPLES_DEF = 512;

endpackage

// File: rtl/peak_hold_meter_if.sv
// Sample/display bundle of the peak-hold meter.
//   sample_en   : one-cycle strobe per sample, din valid only when high
//   din         : rectified sample magnitude (unsigned)
//   level       : last accepted sample
//   peak        : current held/decaying peak
//   hold_active : high while the peak is being held
//   leds        : VU bar plus peak-hold dot
// master = sample source / display consumer, slave = the meter.
interface peak_hold_meter_if #(
  parameter int DW    = 6,
  parameter int NLEDS = 8
);
  logic             sample_en;
  logic [DW-1:0]    din;
  logic [DW-1:0]    level;
  logic [DW-1:0]    peak;
  logic             hold_active;
  logic [NLEDS-1:0] leds;

  modport master (
    output sample_en, din,
    input  level, peak, hold_active, leds
  );

  modport slave (
    input  sample_en, din,
    output level, peak, hold_active, leds
  );
endinterface

// File: rtl/peak_hold_meter_bar_encoder.sv
// bar_encoder: registered VU-bar encoder.
//   clk, rst : clock, synchronous active-high reset
//   level    : value shown as a bar of ceil(level/8) lit LEDs from leds[0]
//   peak     : value shown as a single dot at leds[ceil(peak/8)-1]
//   leds     : bar OR dot, registered (one cycle after level/peak)
module bar_encoder
  import display_pkg::*;
#(
  parameter int DW    = 6,
  parameter int NLEDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    level,
  input  logic [DW-1:0]    peak,
  output logic [NLEDS-1:0] leds
);

  localparam int STEP_SH = $clog2(LED_CODES_PER_STEP);

  // Number of LEDs covering v: ceil(v / LED_CODES_PER_STEP).
  function automatic int led_steps(input logic [DW-1:0] v);
    logic [DW:0] sum;
    sum = {1'b0, v} + (DW+1)'(LED_CODES_PER_STEP - 1);
    return int'(sum >> STEP_SH);
  endfunction

  function automatic logic [NLEDS-1:0] bar_mask(input logic [DW-1:0] v);
    logic [NLEDS-1:0] m;
    int               n;
    m = '0;
    n = led_steps(v);
    for (int i = 0; i < NLEDS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [NLEDS-1:0] dot_mask(input logic [DW-1:0] v);
    logic [NLEDS-1:0] m;
    int               n;
    m = '0;
    n = led_steps(v);
    for (int i = 0; i < NLEDS; i++) begin
      if (n == i + 1) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Stage p1: encoded display word
  always_ff @(posedge clk) begin
    if (rst) begin
      leds <= '0;
    end else begin
      leds <= bar_mask(level) | dot_mask(peak);
    end
  end

endmodule

// File: rtl/peak_hold_meter.sv
// peak_hold_meter: peak tracker with hold-then-decay ballistics driving an
// 8-LED VU bar plus peak-hold dot.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of peak_hold_meter_if (sample_en/din in;
//              level/peak/hold_active/leds out)
// level/peak/hold_active update the cycle after a strobe, leds one cycle later.
module peak_hold_meter
  import display_pkg::*;
#(
  parameter int DW            = 6,
  parameter int NLEDS         = 8,
  parameter int HOLD_SAMPLES  = HOLD_SAMPLES_DEF,
  parameter int DECAY_SAMPLES = DECAY_SAMPLES_DEF,
  parameter int CNT_W         = 15
) (
  input  logic              clk,
  input  logic              rst,
  peak_hold_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_SAMPLES - 1);
  localparam logic [CNT_W-1:0] DECAY_LAST = CNT_W'(DECAY_SAMPLES - 1);

  state_t           state_p0;
  logic [CNT_W-1:0] hold_cnt_p0;
  logic [CNT_W-1:0] decay_cnt_p0;
  logic [DW-1:0]    level_p0;
  logic [DW-1:0]    peak_p0;
  logic             hold_active_p0;
  logic [NLEDS-1:0] leds_p1;

  // Stage p0: sample capture and ballistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0       <= IDLE;
      hold_cnt_p0    <= '0;
      decay_cnt_p0   <= '0;
      level_p0       <= '0;
      peak_p0        <= '0;
      hold_active_p0 <= 1'b0;
    end else if (bus.sample_en) begin
      level_p0 <= bus.din;
      if (bus.din > peak_p0) begin
        // Attack; din==0 can never exceed peak, so zero never enters HOLD.
        peak_p0        <= bus.din;
        hold_cnt_p0    <= '0;
        state_p0       <= HOLD;
        hold_active_p0 <= 1'b1;
      end else if ((bus.din == peak_p0) && (bus.din != '0)) begin
        // Touching the current peak again re-arms the full hold time.
        hold_cnt_p0    <= '0;
        decay_cnt_p0   <= '0;
        state_p0       <= HOLD;
        hold_active_p0 <= 1'b1;
      end else begin
        case (state_p0)
          HOLD: begin
            if (hold_cnt_p0 == HOLD_LAST) begin
              hold_cnt_p0    <= '0;
              decay_cnt_p0   <= '0;
              state_p0       <= DECAY;
              hold_active_p0 <= 1'b0;
            end else begin
              hold_cnt_p0 <= hold_cnt_p0 + CNT_W'(1);
            end
          end
          DECAY: begin
            if (decay_cnt_p0 == DECAY_LAST) begin
              // DECAY always has peak>=1, so this cannot underflow.
              peak_p0      <= peak_p0 - DW'(1);
              decay_cnt_p0 <= '0;
              if (peak_p0 == DW'(1)) begin
                state_p0 <= IDLE;
              end
            end else begin
              decay_cnt_p0 <= decay_cnt_p0 + CNT_W'(1);
            end
          end
          default: begin
            state_p0 <= IDLE;
          end
        endcase
      end
    end
  end

  // Stage p1: LED encoding
  bar_encoder #(
    .DW    (DW),
    .NLEDS (NLEDS)
  ) u_bar_encoder (
    .clk   (clk),
    .rst   (rst),
    .level (level_p0),
    .peak  (peak_p0),
    .leds  (leds_p1)
  );

  assign bus.level       = level_p0;
  assign bus.peak        = peak_p0;
  assign bus.hold_active = hold_active_p0;
  assign bus.leds        = leds_p1;

endmodule

// File: tb/tb_peak_hold_meter.sv
// Testbench for peak_hold_meter (HOLD_SAMPLES=4, DECAY_SAMPLES=2).
module tb_peak_hold_meter;
  import display_pkg::*;

  localparam int DW = 6;
  localparam int NL = 8;
  localparam int HS = 4;
  localparam int DS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  peak_hold_meter_if #(.DW(DW), .NLEDS(NL)) bus ();

  peak_hold_meter #(
    .DW            (DW),
    .NLEDS         (NL),
    .HOLD_SAMPLES  (HS),
    .DECAY_SAMPLES (DS),
    .CNT_W         (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] level;
    logic [DW-1:0] peak;
    logic          hold;
    logic [NL-1:0] leds;
  } exp_t;

  typedef struct {
    logic r;
    logic e;
    int   d;
    int   lv;
    int   pk;
    int   hd;
    int   ld;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  int checks = 0;
  int passed = 0;

  // Reference model state: 0=idle 1=hold 2=decay
  int m_level = 0, m_peak = 0, m_state = 0, m_hc = 0, m_dc = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  // Lit LED i when level exceeds 8*i; dot at (peak-1)/8.
  function automatic int enc(input int lv, input int pk);
    int m;
    m = 0;
    for (int i = 0; i < NL; i++) begin
      if (lv > 8 * i) m |= (1 << i);
    end
    if (pk > 0) m |= (1 << ((pk - 1) / 8));
    return m;
  endfunction

  task automatic model_step(input logic r, input logic e, input int d);
    if (r) begin
      m_level = 0; m_peak = 0; m_state = 0; m_hc = 0; m_dc = 0;
    end else if (e) begin
      m_level = d;
      if (d > m_peak) begin
        m_peak = d; m_hc = 0; m_state = 1;
      end else if (d == m_peak && d != 0) begin
        m_hc = 0; m_dc = 0; m_state = 1;
      end else if (m_state == 1) begin
        m_hc++;
        if (m_hc == HS) begin m_hc = 0; m_dc = 0; m_state = 2; end
      end else if (m_state == 2) begin
        m_dc++;
        if (m_dc == DS) begin
          m_dc = 0;
          m_peak--;
          if (m_peak == 0) m_state = 0;
        end
      end
    end
  endtask

  // One clock: drive at negedge, push expectation, compare at next negedge.
  task automatic cycle(input logic r, input logic e, input int d, output exp_t got);
    exp_t x;
    rst           = r;
    bus.sample_en = e;
    bus.din       = d[DW-1:0];
    x.leds = r ? '0 : NL'(enc(m_level, m_peak));
    model_step(r, e, d);
    x.level = m_level[DW-1:0];
    x.peak  = m_peak[DW-1:0];
    x.hold  = (m_state == 1);
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    chk("sb_level", int'(bus.level), int'(x.level));
    chk("sb_peak", int'(bus.peak), int'(x.peak));
    chk("sb_hold", int'(bus.hold_active), int'(x.hold));
    chk("sb_leds", int'(bus.leds), int'(x.leds));
    got.level = bus.level;
    got.peak  = bus.peak;
    got.hold  = bus.hold_active;
    got.leds  = bus.leds;
  endtask

  task automatic add(input logic r, input logic e, input int d,
                     input int lv, input int pk, input int hd, input int ld);
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.lv = lv; v.pk = pk; v.hd = hd; v.ld = ld;
    tbl.push_back(v);
  endtask

  initial begin
    exp_t g;
    rst           = 1'b1;
    bus.sample_en = 1'b0;
    bus.din       = '0;

    // Reset, then din=63 without strobes
    add(1, 0, 63, 0, 0, 0, 8'h00);
    add(1, 0, 63, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) add(0, 0, 63, 0, 0, 0, 8'h00);
    // Attack and encode
    add(0, 1, 20, 20, 20, 1, 8'h00);
    add(0, 0, 0, 20, 20, 1, 8'h07);
    // Hold for 4 strobes, then decay every 2
    add(0, 1, 0, 0, 20, 1, 8'h07);
    add(0, 1, 0, 0, 20, 1, 8'h04);
    add(0, 1, 0, 0, 20, 1, 8'h04);
    add(0, 1, 0, 0, 20, 0, 8'h04);
    add(0, 1, 0, 0, 20, 0, 8'h04);
    add(0, 1, 0, 0, 19, 0, 8'h04);
    add(0, 1, 0, 0, 19, 0, 8'h04);
    add(0, 1, 0, 0, 18, 0, 8'h04);
    // Re-arm at 18, full hold again, then override with 40
    add(0, 1, 18, 18, 18, 1, 8'h04);
    add(0, 1, 0, 0, 18, 1, 8'h07);
    add(0, 1, 0, 0, 18, 1, 8'h04);
    add(0, 1, 0, 0, 18, 1, 8'h04);
    add(0, 1, 0, 0, 18, 0, 8'h04);
    add(0, 1, 40, 40, 40, 1, 8'h04);
    add(0, 0, 0, 40, 40, 1, 8'h1F);
    add(0, 1, 0, 0, 40, 1, 8'h1F);
    add(0, 0, 0, 0, 40, 1, 8'h10);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].e, tbl[i].d, g);
      chk($sformatf("tbl_level[%0d]", i), int'(g.level), tbl[i].lv);
      chk($sformatf("tbl_peak[%0d]", i), int'(g.peak), tbl[i].pk);
      chk($sformatf("tbl_hold[%0d]", i), int'(g.hold), tbl[i].hd);
      chk($sformatf("tbl_leds[%0d]", i), int'(g.leds), tbl[i].ld);
    end

    // Decay to zero from peak=1 with single-cycle strobes
    cycle(1, 0, 0, g);
    cycle(0, 1, 1, g);
    chk("z_attack_peak", int'(g.peak), 1);
    chk("z_attack_hold", int'(g.hold), 1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 0, g);
      if (i == 3) begin
        chk("z_decay_entry_hold", int'(g.hold), 0);
        chk("z_decay_entry_peak", int'(g.peak), 1);
      end
      cycle(0, 0, 0, g);
    end
    chk("z_final_peak", int'(g.peak), 0);
    chk("z_final_hold", int'(g.hold), 0);
    chk("z_final_leds", int'(g.leds), 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, g);
    chk("z_no_underflow", int'(g.peak), 0);
    chk("z_no_underflow_leds", int'(g.leds), 0);

    // Reset mid-decay at peak=12
    cycle(0, 1, 12, g);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, g);
      cycle(0, 0, 0, g);
    end
    chk("rd_pre_peak", int'(g.peak), 12);
    chk("rd_pre_hold", int'(g.hold), 0);
    cycle(1, 0, 0, g);
    chk("rd_peak", int'(g.peak), 0);
    chk("rd_leds", int'(g.leds), 0);
    chk("rd_hold", int'(g.hold), 0);
    cycle(0, 1, 9, g);
    chk("rd_new_peak", int'(g.peak), 9);
    chk("rd_new_level", int'(g.level), 9);
    chk("rd_leds_lat1", int'(g.leds), 0);
    cycle(0, 0, 0, g);
    chk("rd_leds_lat2", int'(g.leds), 8'h03);

    // Random mix of strobes, gaps, bursts and occasional resets
    for (int i = 0; i < 400; i++) begin
      logic r, e;
      int   d;
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : 0;
      cycle(r, e, d, g);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
